// File: rtl/fe_pc_gen.sv
// Fetch PC generator: issues in-order aligned fetches, buffers returned blocks for decode, squashes wrong-path work on redirect.
// Optional misaligned-redirect fault enabled by defining FETCH_ALIGN_CHECK_EN.
module fe_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_jump,
  input  logic [63:0] jump_pc,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_data,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [63:0] fd_pc,
  output logic [63:0] fd_data,
  output logic        fetch_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] data;
  } fb_entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [63:0]   pc_q, pc_d, imem_addr_q, imem_addr_d, fd_pc_q, fd_pc_d, fd_data_q, fd_data_d;
  logic          imem_req_q, imem_req_d, fd_valid_q, fd_valid_d, fault_q, fault_d;
  logic [CW-1:0] occ_q, occ_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  fb_entry_t     fb_q [DEPTH];
  logic [63:0]   pq_q [DEPTH];

  logic          grant, rv_ok, pop, push, jump_bad;
  logic [63:0]   jump_tgt;
  logic [CW:0]   total_d;
  fb_entry_t     new_ent;

  always_comb begin
    jump_tgt = {jump_pc[63:3], 3'b000};
`ifdef FETCH_ALIGN_CHECK_EN
    jump_bad = (jump_pc[2:0] != 3'b000);
`else
    jump_bad = 1'b0;
`endif
    grant   = imem_req_q & imem_gnt;
    // a response with nothing outstanding is a protocol error and is ignored
    rv_ok   = imem_rvalid & (inflight_q != '0);
    pop     = fd_valid_q & fd_ready & ~do_jump;
    push    = rv_ok & ~do_jump & (discard_q == '0);
    new_ent = '{pc: pq_q[pq_rd_q], data: imem_data};

    inflight_d = inflight_q + CW'(grant) - CW'(rv_ok);
    pq_wr_d    = grant ? ptr_inc(pq_wr_q) : pq_wr_q;
    pq_rd_d    = rv_ok ? ptr_inc(pq_rd_q) : pq_rd_q;

    pc_d = pc_q;
    if (grant)   pc_d = pc_q + 64'd8;
    if (do_jump) pc_d = jump_tgt;
    fault_d = do_jump ? jump_bad : fault_q;

    // everything still outstanding after this cycle belongs to the old path
    discard_d = discard_q;
    if (do_jump)                       discard_d = inflight_d;
    else if (rv_ok && discard_q != '0) discard_d = discard_q - CW'(1);

    if (do_jump) begin
      occ_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      occ_d = occ_q + CW'(push) - CW'(pop);
      rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
      wr_d  = push ? ptr_inc(wr_q) : wr_q;
    end

    fd_valid_d = (occ_d != '0);
    fd_pc_d    = fd_pc_q;
    fd_data_d  = fd_data_q;
    if (fd_valid_d) begin
      // new block lands directly at the head when the buffer drains this cycle
      if (push && (wr_q == rd_d)) {fd_pc_d, fd_data_d} = new_ent;
      else                        {fd_pc_d, fd_data_d} = fb_q[rd_d];
    end

    total_d     = {1'b0, occ_d} + {1'b0, inflight_d};
    imem_req_d  = ~do_jump & ~fault_d & (total_d < (CW+1)'(DEPTH));
    imem_addr_d = pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
      fault_q     <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      pq_rd_q     <= '0;
      pq_wr_q     <= '0;
      fd_valid_q  <= 1'b0;
      fd_pc_q     <= '0;
      fd_data_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      fault_q     <= fault_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      pq_rd_q     <= pq_rd_d;
      pq_wr_q     <= pq_wr_d;
      fd_valid_q  <= fd_valid_d;
      fd_pc_q     <= fd_pc_d;
      fd_data_q   <= fd_data_d;
    end
  end

  // storage arrays are qualified by occupancy/inflight counters, so no reset needed
  always_ff @(posedge clk) begin
    if (push)  fb_q[wr_q]    <= new_ent;
    if (grant) pq_q[pq_wr_q] <= imem_addr_q;
  end

  assign imem_addr   = imem_addr_q;
  assign imem_req    = imem_req_q;
  assign fd_valid    = fd_valid_q;
  assign fd_pc       = fd_pc_q;
  assign fd_data     = fd_data_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fe_pc_gen.sv
// Scoreboard bench for fe_pc_gen: behavioural imem + epoch-tagged request model feeding an expected-block queue.
module tb_fe_pc_gen;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0, rst;
  logic        do_jump, imem_req, imem_gnt, imem_rvalid, fd_valid, fd_ready, fetch_fault;
  logic [63:0] jump_pc, imem_addr, imem_data, fd_pc, fd_data;

  fe_pc_gen #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .do_jump(do_jump), .jump_pc(jump_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_data(imem_data),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_pc(fd_pc), .fd_data(fd_data),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int epoch; } req_t;
  typedef struct { logic [63:0] pc; logic [63:0] data; } blk_t;

  req_t        pend[$];   // granted, response not yet returned
  blk_t        expq[$];   // blocks the DUT should hold for decode, oldest first
  int          n_chk = 0, n_fail = 0, epoch = 0;
  logic [63:0] exp_pc;
  bit          fault_m = 1'b0, jump_prev = 1'b0;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: check registered state, drive inputs, then update the model with this cycle's events
  task automatic step(input bit gnt, input bit rv, input bit rdy, input bit jmp,
                      input logic [63:0] tgt, input bit spur);
    req_t r;
    @(posedge clk); #1;
    check("imem_req", imem_req, 64'(!jump_prev && !fault_m && (expq.size() + pend.size() < DEPTH)));
    check("fetch_fault", fetch_fault, 64'(fault_m));
    check("fd_valid", fd_valid, 64'(expq.size() > 0));
    if (expq.size() > 0) begin
      check("fd_pc", fd_pc, expq[0].pc);
      check("fd_data", fd_data, expq[0].data);
    end
    if (imem_req) check("imem_addr", imem_addr, exp_pc);
    imem_gnt    = gnt;
    imem_rvalid = (rv && pend.size() > 0) || spur;
    imem_data   = (pend.size() > 0) ? mem_word(pend[0].addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    fd_ready    = rdy;
    do_jump     = jmp;
    jump_pc     = tgt;
    @(negedge clk);
    if (imem_rvalid && pend.size() > 0) begin
      r = pend.pop_front();
      if (!do_jump && r.epoch == epoch) expq.push_back('{r.addr, mem_word(r.addr)});
    end
    if (imem_req && imem_gnt) begin
      pend.push_back('{exp_pc, epoch});
      exp_pc = exp_pc + 64'd8;
    end
    if (do_jump) begin
      epoch++;
      expq.delete();
      exp_pc = {tgt[63:3], 3'b000};
`ifdef FETCH_ALIGN_CHECK_EN
      fault_m = (tgt[2:0] != 3'b000);
`endif
    end
    jump_prev = do_jump;
  endtask

  // monitor: every decode handshake must deliver the oldest expected block
  initial begin
    blk_t b;
    forever begin
      @(negedge clk);
      if (!rst && fd_valid && fd_ready && !do_jump) begin
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fd_handshake: got pc %h, expected no block", fd_pc);
        end else begin
          b = expq.pop_front();
          check("hs_pc", fd_pc, b.pc);
          check("hs_data", fd_data, b.data);
        end
      end
    end
  end

  initial begin
    logic [63:0] t;
    rst = 1'b1; do_jump = 0; jump_pc = '0; imem_gnt = 0; imem_rvalid = 0;
    imem_data = '0; fd_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 64'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_fd_valid", fd_valid, 64'd0);
    check("rst_fd_pc", fd_pc, 64'd0);
    check("rst_fd_data", fd_data, 64'd0);
    check("rst_fetch_fault", fetch_fault, 64'd0);
    exp_pc = RESET_PC;
    rst = 1'b0;

    repeat (20) step(1, 1, 1, 0, '0, 0);           // streaming
    repeat (6)  step(1, 1, 0, 0, '0, 0);           // decode stalled, buffer fills
    repeat (10) step(1, 1, 1, 0, '0, 0);
    repeat (6)  step(0, 1, 1, 0, '0, 0);           // drain outstanding
    step(0, 0, 1, 0, '0, 1);                       // stray response, nothing in flight
    repeat (3)  step(1, 0, 1, 0, '0, 0);           // two requests outstanding
    step(0, 0, 1, 1, 64'h1000, 0);
    repeat (10) step(1, 1, 1, 0, '0, 0);
    step(1, 0, 1, 0, '0, 0);
    step(1, 1, 1, 1, 64'h2000, 0);                 // redirect with grant and response
    repeat (8)  step(1, 1, 1, 0, '0, 0);
    step(0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0);  // wrap through zero
    repeat (10) step(1, 1, 1, 0, '0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    step(0, 1, 1, 1, 64'h1004, 0);
    repeat (5)  step(1, 1, 1, 0, '0, 0);
    step(0, 1, 1, 1, 64'h2000, 0);
    repeat (8)  step(1, 1, 1, 0, '0, 0);
`else
    step(0, 1, 1, 1, 64'h3005, 0);                 // low bits forced to zero
    repeat (8)  step(1, 1, 1, 0, '0, 0);
`endif
    repeat (1500) begin
      t = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       t = 64'h1000;
        1:       t = 64'hFFFF_FFFF_FFFF_FFF8;
        default: ;
      endcase
`ifdef FETCH_ALIGN_CHECK_EN
      t[2:0] = 3'b000;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, t, 0);
    end
    repeat (30) step(0, 1, 1, 0, '0, 0);
    check("drain_buffer_empty", 64'(expq.size()), 64'd0);
    check("drain_inflight_empty", 64'(pend.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fe_pc_gen.md
Name: fe_pc_gen

Overview:
- Fetch-stage PC generator and redirect unit; sits directly upstream of decode/dispatch and consumes the branch unit's redirect (do_jump, jump_pc).
- Holds the architectural fetch PC and issues in-order 64-bit aligned fetch requests to instruction memory.
- Buffers returned fetch blocks for decode and squashes wrong-path requests and data on every redirect.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded at reset; must be 8-byte aligned.
- DEPTH, 2, fetch buffer entries (legal 2..4); also caps buffered + in-flight blocks.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- do_jump  in  1  redirect strobe from branch unit, single-cycle
- jump_pc  in  64  redirect target, valid with do_jump
- imem_addr  out  64  fetch address, always 8-byte aligned
- imem_req  out  1  fetch request
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid; responses return in request order
- imem_data  in  64  response data
- fd_valid  out  1  buffer head valid to decode
- fd_ready  in  1  decode accepts head
- fd_pc  out  64  PC of head block
- fd_data  out  64  head block data
- fetch_fault  out  1  see Optional Feature; tied 0 when compiled out

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset values (asynchronous):
  - pc=RESET_PC; buffer empty; inflight=0; discard=0.
  - imem_req=0; imem_addr=RESET_PC.
  - fd_valid=0; fd_pc=0; fd_data=0; fetch_fault=0.
- Request issue:
  - imem_req=1 when (occupancy + inflight) < DEPTH and no fault.
  - imem_addr=pc, registered.
  - On imem_req & imem_gnt: pc<=pc+8 (64-bit wrap, no trap); inflight+1.
  - imem_req and imem_addr stay stable until granted or a redirect occurs.
- Response handling:
  - Each imem_rvalid pairs with the oldest in-flight request; inflight-1.
  - If discard>0: decrement discard and drop the data.
  - Otherwise: write {pc of request, data} to the buffer tail.
  - Request PCs are tracked in a DEPTH-entry in-order PC queue.
- Decode handshake:
  - Head pops on fd_valid & fd_ready.
  - fd_* are registered from the head entry. fd_valid follows occupancy with 1-cycle latency from the rvalid write.
  - fd_pc/fd_data hold while fd_valid & ~fd_ready.
  - Minimum latency: gnt in cycle N, rvalid in cycle N+1, fd_valid in cycle N+2.
- Redirect (do_jump, highest priority, ignores fd_ready):
  - Next edge: pc<=jump_pc; buffer flushed; fd_valid<=0; imem_req<=0 for that cycle.
  - discard<=inflight counted after this cycle's gnt and rvalid are applied. A request granted in the redirect cycle is therefore discarded, and an rvalid arriving in the redirect cycle is dropped.
  - New-target request issues the following cycle. It may be granted while discards remain outstanding; ordering keeps old-path data dropped.
- Back-to-back redirects: the latest target wins; discard accumulates correctly.
- Boundaries:
  - Full (occupancy+inflight==DEPTH): no request.
  - Pop and push in the same cycle on a full buffer is allowed.
  - pc 64'hFFFF_FFFF_FFFF_FFF8 + 8 wraps to 0.
  - rvalid with inflight==0 is a protocol error; ignore it and do not underflow.
- Reset mid-operation discards all in-flight state. Responses arriving after reset release for pre-reset requests are counted as protocol error and ignored (inflight==0).

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with jump_pc[2:0]!=0 sets fetch_fault=1 (sticky), flushes the buffer as a normal redirect, and blocks all requests.
  - The next aligned redirect clears fetch_fault and resumes fetch at that target.
- Not defined: jump_pc[2:0] is forced to 0 and fetch_fault is tied 0.

Test Plan:
- Reset release, DEPTH=2, gnt=1, rvalid 1 cycle later, fd_ready=1 → imem_addr sequence 0,8,16,…; fd_pc matches with 2-cycle latency; no bubbles after fill.
- fd_ready=0 for 5 cycles → after 2 blocks buffered imem_req=0; data stays stable; releasing fd_ready resumes in order with nothing lost.
- 2 requests in flight, do_jump jump_pc=64'h1000 → both old responses dropped; the first fd_pc after redirect is 64'h1000 with correct data.
- do_jump coinciding with imem_gnt and imem_rvalid → granted request discarded, arriving data dropped; next imem_addr=jump_pc.
- pc=64'hFFFF_FFFF_FFFF_FFF8 granted → next imem_addr=0.
- FETCH_ALIGN_CHECK_EN, jump_pc=64'h1004 → fetch_fault=1, imem_req=0; then jump_pc=64'h2000 → fault clears and fetch resumes at 64'h2000.
